// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 32-bit words into a byte-wide instruction memory, holding the cpu until loaded
module instr_mem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic word_valid,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic word_last,
  output logic word_ready,
  output logic mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic busy,
  output logic done,
  output logic error,
  output logic cpu_hold,
  output logic [15:0] word_count
);
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} state_t;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_PTR = ADDRESS_WIDTH'(MEM_BYTES - 4);
  state_t state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic [1:0] byte_idx;
  logic [1:0] nxt_idx;
  logic [DATA_WIDTH-1:0] word;
  logic last;
  logic ovf;
  logic can_start;
  assign nxt_idx = byte_idx + 2'd1;
  assign ovf = ptr > LAST_PTR;
  assign can_start = (state == IDLE) || (state == DONE) || (state == ERROR);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: state_nxt = start ? ACCEPT : state;
      ACCEPT: state_nxt = !word_valid ? ACCEPT : ovf ? ERROR : WRITE;
      WRITE: state_nxt = byte_idx != 2'd3 ? WRITE : last ? DONE : ACCEPT;
      default: state_nxt = IDLE;
    endcase
  end
  // mem_addr/mem_wdata are loaded one edge ahead so they hold once writing stops
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      byte_idx <= '0;
      word <= '0;
      last <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      word_count <= '0;
    end else if (can_start && start) begin
      ptr <= ADDRESS_WIDTH'(BASE_ADDR);
      word_count <= '0;
    end else if (state == ACCEPT && word_valid) begin
      word <= word_data;
      last <= word_last;
      byte_idx <= '0;
      if (!ovf) begin
        mem_addr <= ptr;
        mem_wdata <= word_data[7:0];
      end
    end else if (state == WRITE) begin
      byte_idx <= nxt_idx;
      if (byte_idx == 2'd3) begin
        ptr <= ptr + ADDRESS_WIDTH'(4);
        word_count <= word_count + 16'd1;
      end else begin
        mem_addr <= ptr + ADDRESS_WIDTH'(nxt_idx);
        mem_wdata <= word[{nxt_idx, 3'b000} +: 8];
      end
    end
  end
  assign word_ready = state == ACCEPT;
  assign mem_we = state == WRITE;
  assign busy = (state == ACCEPT) || (state == WRITE);
  assign done = state == DONE;
  assign error = state == ERROR;
  assign cpu_hold = state != DONE;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of byte-write order, throughput, overflow, reset and restart
module tb_instr_mem_loader;
  logic clk = 0;
  logic rst = 1;
  logic start = 0, start2 = 0;
  logic word_valid = 0, word_last = 0;
  logic [31:0] word_data = '0;
  logic word_ready, mem_we, busy, done, error, cpu_hold;
  logic [31:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [15:0] word_count;
  logic word_ready2, mem_we2, busy2, done2, error2, cpu_hold2;
  logic [31:0] mem_addr2;
  logic [7:0] mem_wdata2;
  logic [15:0] word_count2;
  logic [7:0] mem [64];
  int nwr = 0, nwr2 = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  instr_mem_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid), .word_data(word_data),
    .word_last(word_last), .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
    .word_count(word_count)
  );
  instr_mem_loader #(.BASE_ADDR(12), .MEM_BYTES(16)) u_ovf (
    .clk(clk), .rst(rst), .start(start2), .word_valid(word_valid), .word_data(word_data),
    .word_last(word_last), .word_ready(word_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .busy(busy2), .done(done2), .error(error2), .cpu_hold(cpu_hold2),
    .word_count(word_count2)
  );
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      nwr <= nwr + 1;
    end
    if (mem_we2) nwr2 <= nwr2 + 1;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [31:0] bw [3];
    logic [7:0] exp_b [12];
    int base, k, n, rdy, bad;
    logic hs;
    bw = '{32'h11223344, 32'h55667788, 32'hAABBCCDD};
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    tick(2);
    rst = 0;
    tick();
    chk("rst_ready", {31'b0, word_ready}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", {24'b0, mem_wdata}, 0);
    chk("rst_flags", {28'b0, busy, done, error, cpu_hold}, 32'b0001);
    chk("rst_count", {16'b0, word_count}, 0);
    // single word
    start = 1; tick(); start = 0;
    chk("s1_accept", {30'b0, word_ready, busy}, 32'b11);
    word_valid = 1; word_data = 32'h00500093; word_last = 1; tick(); word_valid = 0;
    chk("s1_b0", {word_ready, mem_we, 6'b0, mem_addr[15:0], mem_wdata}, {1'b0, 1'b1, 6'b0, 16'd0, 8'h93});
    tick();
    chk("s1_b1", {mem_we, 7'b0, mem_addr[15:0], mem_wdata}, {1'b1, 7'b0, 16'd1, 8'h00});
    tick();
    chk("s1_b2", {mem_we, 7'b0, mem_addr[15:0], mem_wdata}, {1'b1, 7'b0, 16'd2, 8'h50});
    tick();
    chk("s1_b3", {mem_we, 7'b0, mem_addr[15:0], mem_wdata}, {1'b1, 7'b0, 16'd3, 8'h00});
    tick();
    chk("s1_done", {27'b0, mem_we, busy, done, error, cpu_hold}, 32'b00100);
    chk("s1_count", {16'b0, word_count}, 1);
    chk("s1_hold_addr", mem_addr, 3);
    chk("s1_nwr", nwr, 4);
    chk("s1_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h00500093);
    // restart from DONE, then a three-word burst with valid held high
    start = 1; tick(); start = 0;
    chk("re_accept", {29'b0, word_ready, done, cpu_hold}, 32'b101);
    chk("re_count", {16'b0, word_count}, 0);
    base = nwr; k = 0; n = 0; rdy = 0;
    word_valid = 1; word_data = bw[0]; word_last = 0;
    while (k < 3 && n < 40) begin
      hs = word_ready;
      if (word_ready) rdy++;
      tick(); n++;
      if (hs) begin
        k++;
        if (k < 3) begin
          word_data = bw[k];
          word_last = (k == 2);
        end else word_valid = 0;
      end
    end
    word_valid = 0;
    chk("b_words", k, 3);
    chk("b_cycles", n, 11);
    chk("b_ready", rdy, 3);
    tick(4);
    chk("b_done", {30'b0, done, cpu_hold}, 32'b10);
    chk("b_count", {16'b0, word_count}, 3);
    chk("b_nwr", nwr - base, 12);
    for (int i = 0; i < 12; i++) chk($sformatf("b_mem%0d", i), {24'b0, mem[i]}, {24'b0, exp_b[i]});
    // start during WRITE is ignored; 7-cycle source gap
    start = 1; tick(); start = 0;
    base = nwr;
    word_valid = 1; word_data = 32'hCAFEF00D; word_last = 0; tick(); word_valid = 0;
    start = 1; tick(); start = 0;
    tick(3);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (!word_ready || mem_we) bad++;
      tick();
    end
    chk("g_idle_bad", bad, 0);
    chk("g_nwr_gap", nwr - base, 4);
    word_valid = 1; word_data = 32'h0BADBEEF; word_last = 1; tick(); word_valid = 0;
    tick(4);
    chk("g_done", {31'b0, done}, 1);
    chk("g_count", {16'b0, word_count}, 2);
    chk("g_nwr", nwr - base, 8);
    chk("g_mem_lo", {mem[3], mem[2], mem[1], mem[0]}, 32'hCAFEF00D);
    chk("g_mem_hi", {mem[7], mem[6], mem[5], mem[4]}, 32'h0BADBEEF);
    // reset during byte 1
    start = 1; tick(); start = 0;
    base = nwr;
    word_valid = 1; word_data = 32'h12345678; word_last = 1; tick(); word_valid = 0;
    tick();
    chk("r_b1", {mem_we, 7'b0, mem_addr[15:0], mem_wdata}, {1'b1, 7'b0, 16'd1, 8'h56});
    rst = 1; tick(); rst = 0;
    chk("r_out", {mem_we, word_ready, busy, done, error, cpu_hold, 26'b0}, {6'b000001, 26'b0});
    chk("r_addr", mem_addr, 0);
    chk("r_wdata", {24'b0, mem_wdata}, 0);
    chk("r_count", {16'b0, word_count}, 0);
    tick(4);
    chk("r_nwr", nwr - base, 2);
    chk("r_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'hCAFE5678);
    chk("r_idle", {30'b0, word_ready, mem_we}, 0);
    // overflow on the instance based at MEM_BYTES-4
    start2 = 1; tick(); start2 = 0;
    word_valid = 1; word_data = 32'hA1B2C3D4; word_last = 0; tick(); word_valid = 0;
    chk("o_b0", {mem_we2, 7'b0, mem_addr2[15:0], mem_wdata2}, {1'b1, 7'b0, 16'd12, 8'hD4});
    tick(3);
    chk("o_b3", {mem_we2, 7'b0, mem_addr2[15:0], mem_wdata2}, {1'b1, 7'b0, 16'd15, 8'hA1});
    tick();
    chk("o_accept", {31'b0, word_ready2}, 1);
    word_valid = 1; word_data = 32'h00000099; word_last = 1; tick(); word_valid = 0;
    chk("o_err", {27'b0, mem_we2, busy2, done2, error2, cpu_hold2}, 32'b00011);
    tick(3);
    chk("o_stay", {30'b0, error2, mem_we2}, 32'b10);
    chk("o_count", {16'b0, word_count2}, 1);
    chk("o_nwr", nwr2, 4);
    start2 = 1; tick(); start2 = 0;
    chk("o_restart", {29'b0, word_ready2, error2, cpu_hold2}, 32'b101);
    chk("o_recount", {16'b0, word_count2}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer-side companion to the byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes each word into the memory's byte-wide write port as four little-endian byte writes: byte 0 is bits 7:0, at the lowest address. While a load is in progress it holds the CPU in reset, so the core fetches only after the image is fully written.

Parameters:
ADDRESS_WIDTH, 32, width of mem_addr and the internal address pointer
DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
BASE_ADDR, 0, byte address where the first word is written; must be a multiple of 4
MEM_BYTES, 65536, memory size in bytes; a write must never go beyond MEM_BYTES-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
word_valid  in  1  source has a word on word_data
word_data  in  DATA_WIDTH  instruction word
word_last  in  1  marks the final word of the image; qualified by word_valid
word_ready  out  1  loader can accept a word this cycle
mem_we  out  1  byte write enable to instruction memory
mem_addr  out  ADDRESS_WIDTH  byte address of the write
mem_wdata  out  8  byte to write
busy  out  1  high in ACCEPT or WRITE
done  out  1  high in DONE
error  out  1  high in ERROR (image would overflow memory)
cpu_hold  out  1  holds the core in reset; low only in DONE
word_count  out  16  number of words fully written in the current or last load

Behaviour:
- Reset: when rst is high at a clock edge, the FSM goes to IDLE.
  - Reset values: word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1, word_count=0.
  - Internal registers (address pointer, byte index, word buffer, last flag) are cleared.
  - rst overrides every other input.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR. All outputs are decoded from registered state; no input-to-output combinational path.
- IDLE: on start, set ptr=BASE_ADDR, word_count=0, go to ACCEPT.
- ACCEPT:
  - word_ready=1.
  - A handshake occurs when word_valid && word_ready at a rising edge. On handshake, latch word_data and word_last.
  - If ptr > MEM_BYTES-4, go to ERROR; no bytes are written.
  - Otherwise set byte_idx=0 and go to WRITE.
  - word_valid low means stay in ACCEPT indefinitely. No timeout.
- WRITE: lasts exactly 4 cycles, byte_idx = 0,1,2,3.
  - Outputs each cycle: mem_we=1, mem_addr=ptr+byte_idx, mem_wdata=word[8*byte_idx+7 : 8*byte_idx].
  - word_ready=0 throughout.
  - At the end of the byte_idx=3 cycle: ptr+=4, word_count+=1. Then go to DONE if the latched last flag is set, else to ACCEPT.
- Timing: the word accepted at edge n is written in cycles n+1..n+4. The next handshake can occur no earlier than the edge ending cycle n+5. Peak throughput is 1 word per 5 cycles.
- DONE: done=1, cpu_hold=0, word_count held. start goes to ACCEPT with ptr=BASE_ADDR and word_count=0.
- ERROR: error=1, cpu_hold=1, word_count held. start restarts exactly as from DONE.
- Boundary cases:
  - start in ACCEPT or WRITE: ignored.
  - word_valid outside ACCEPT: ignored; the source must hold the word until it sees ready.
  - A word whose last byte lands exactly at MEM_BYTES-1 is legal.
  - word_count wraps modulo 2^16.
  - Reset mid-WRITE: mem_we drops on the cycle after the reset edge. Bytes already written stay in memory; the remaining bytes are not written.
  - mem_addr and mem_wdata hold their last values when mem_we=0, except that reset clears them.

Test Plan:
- Single word: BASE_ADDR=0, start, then 0x00500093 with last=1 -> writes 93@0, 00@1, 50@2, 00@3 on four consecutive cycles. Then done=1, cpu_hold=0, word_count=1.
- Three-word burst with word_valid held high: 0x11223344, 0x55667788, 0xAABBCCDD (last on the third) -> word_ready high 1 of every 5 cycles; 12 byte writes at addresses 0..11 in little-endian order; word_count=3.
- Source gaps: word_valid deasserted for 7 cycles between words -> loader stays in ACCEPT, mem_we=0; no extra or duplicate writes.
- Overflow: BASE_ADDR=MEM_BYTES-4, two words -> first word writes MEM_BYTES-4..MEM_BYTES-1. Second handshake goes to ERROR with no write; error=1, cpu_hold=1, word_count=1.
- Reset mid-write: rst asserted during the byte_idx=1 cycle -> byte 0 and byte 1 are written, no further writes; all outputs at reset values on the next cycle.
- start pulsed during WRITE -> ignored, load completes normally. start in DONE -> reload from BASE_ADDR, word_count restarts at 0, cpu_hold returns to 1.
